pipelined_addsub: RTL
=====================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor with a valid/ready
//  handshake on both sides. It generalises the 8-bit ripple-carry adder to any
//  WIDTH and splits the carry chain into STAGES registered slices to meet timing.
//  It is the arithmetic datapath block placed between operand staging and the
//  result/flag consumers.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; must be >= 2
//  STAGES  2  number of pipeline stages (= latency); WIDTH % STAGES == 0, STAGES >= 1
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: s=a+b+cin   1: s=a-b-cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  s          out  WIDTH  sum/difference, modulo 2^WIDTH
//  carry      out  1      raw carry out of MSB (in sub mode, borrow = ~carry)
//  overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
//  zero       out  1      s == 0
// BEHAVIOUR
//  - Slice width SW = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits
//    [k*SW +: SW] using the carry registered by stage k-1 (stage 0 uses cin_eff).
//  - Sub mode: operand b is inverted at input; cin_eff = sub ? ~cin : cin.
//  - Operands of unprocessed slices and completed sum slices are skewed through
//    the stage registers, together with the sub flag; no combinational path spans
//    more than one slice.
//  - Each stage has valid bit v[k]. Stage k loads when ready[k] = !v[k] || ready[k+1];
//    ready[STAGES] = out_ready. in_ready = ready[0]. Bubbles collapse, so full
//    throughput (1 beat/cycle) holds when out_ready stays 1.
//  - Accept on in_valid && in_ready; deliver on out_valid && out_ready.
//  - Latency: a beat accepted in cycle t is presented on out_valid in cycle
//    t+STAGES with no stalls; each stall cycle adds one.
//  - Outputs are driven from the last stage registers: out_valid = v[STAGES-1].
//    s/carry/overflow/zero hold stable while out_valid && !out_ready. Computing
//    zero and overflow inside the last stage is allowed; no extra cycle.
//  - Ordering is strictly FIFO; no beat is dropped or duplicated.
//  - Reset (async assert, sync deassert handled upstream): all v[k]=0, so
//    out_valid=0. s, carry, overflow and zero = 0. in_ready reads 1 on the first
//    cycle after reset. A reset asserted mid-operation discards all in-flight beats.
//  - When in_valid=0, pipeline data registers may hold stale data; consumers
//    qualify them with out_valid.
//  - STAGES=1 is a fully registered single-cycle ripple adder with the same
//    handshake.
// TESTING  (WIDTH=8, STAGES=2 unless stated)
//  1. add a=FF b=01 cin=0 -> 2 cycles later s=00 carry=1 overflow=0 zero=1
//  2. add a=7F b=01 cin=0 -> s=80 carry=0 overflow=1 zero=0; a=12 b=34 cin=1 -> s=47
//  3. sub a=05 b=07 cin=0 -> s=FE carry=0 overflow=0; sub a=80 b=01 -> s=7F carry=1 overflow=1
//  4. back-to-back 16 random beats, out_ready=1 -> one result per cycle,
//     in order, matching the reference model (a±b±cin mod 256)
//  5. out_ready low for 5 cycles mid-stream -> in_ready drops after 2 beats
//     buffered; outputs stable while stalled; no loss or duplication on release
//  6. rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately;
//     those beats never emerge; WIDTH=32 STAGES=4 rerun of tests 1-4 passes

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// slave is the datapath side, master is the producer/consumer side.
interface pipelined_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, carry, overflow, zero
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, carry, overflow, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor, carry chain cut into
// STAGES registered slices with a per-stage valid/ready handshake.
module pipelined_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_addsub_if.slave  bus
);
    localparam int SW = WIDTH / STAGES;

    logic [STAGES:0] rdy;

    assign rdy[STAGES]  = bus.out_ready;
    assign bus.in_ready = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic             vi;
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] bi;
        logic [WIDTH-1:0] si;
        logic             ci;
        logic             co;
        logic [SW-1:0]    sl;
        logic [WIDTH-1:0] s_d;
        logic             ld;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_in
            // b is inverted once here; borrow-in becomes inverted carry-in
            assign vi = bus.in_valid;
            assign ai = bus.a;
            assign bi = bus.sub ? ~bus.b : bus.b;
            assign ci = bus.sub ^ bus.cin;
            assign si = '0;
        end else begin : g_chain
            assign vi = g_stg[k-1].v_q;
            assign ai = g_stg[k-1].g_fwd.a_q;
            assign bi = g_stg[k-1].g_fwd.b_q;
            assign ci = g_stg[k-1].c_q;
            assign si = g_stg[k-1].s_q;
        end

        assign rdy[k] = !v_q || rdy[k+1];
        assign ld     = rdy[k] && vi;

        assign {co, sl} = {1'b0, ai[k*SW +: SW]}
                        + {1'b0, bi[k*SW +: SW]}
                        + {{SW{1'b0}}, ci};

        // merge this slice into the partially completed sum word
        always_comb begin
            s_d = si;
            s_d[k*SW +: SW] = sl;
        end

        // stage valid, slice carry-out and sum word
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (rdy[k]) begin
                v_q <= vi;
                if (vi) begin
                    c_q <= co;
                    s_q <= s_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // skew the operands along with the partial sum
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ld) begin
                    a_q <= ai;
                    b_q <= bi;
                end
            end
        end else begin : g_last
            logic ov_d;
            logic z_d;
            logic ov_q;
            logic z_q;

            // carry into MSB recovered from the MSB sum bit
            assign ov_d = ai[WIDTH-1] ^ bi[WIDTH-1] ^ s_d[WIDTH-1] ^ co;
            assign z_d  = (s_d == '0);

            // result flags registered alongside the final slice
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ov_q <= 1'b0;
                    z_q  <= 1'b0;
                end else if (ld) begin
                    ov_q <= ov_d;
                    z_q  <= z_d;
                end
            end
        end
    end

    assign bus.out_valid = g_stg[STAGES-1].v_q;
    assign bus.s         = g_stg[STAGES-1].s_q;
    assign bus.carry     = g_stg[STAGES-1].c_q;
    assign bus.overflow  = g_stg[STAGES-1].g_last.ov_q;
    assign bus.zero      = g_stg[STAGES-1].g_last.z_q;
endmodule
